// File: rtl/dds_am_pkg.sv
// dds_am_pkg
//   Shared constants and encodings for the DDS1 amplitude-modulation table
//   reader: default widths, FSM state encoding and stage-1 mode encoding.
package dds_am_pkg;

  localparam int ADDR_W   = 10;  // 1024-word AM envelope table
  localparam int DATA_W   = 16;  // unsigned gain word
  localparam int PHASE_W  = 32;  // modulation phase accumulator
  localparam int SAMPLE_W = 16;  // signed carrier / output sample

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Output treatment chosen when a sample enters stage 1.
  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_AM     = 2'd2
  } mode_e;

endpackage

// File: rtl/dds_am_gain_mult.sv
// dds_am_gain_mult
//   Stage 2 of the AM path: signed carrier x unsigned table gain, scaled by
//   2^-DATA_W with floor rounding, registered. Kept on its own so the
//   multiply maps cleanly onto a DSP block.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_i         stage-1 valid
//   mode_i          stage-1 mode (dds_am_pkg::mode_e encoding)
//   carrier_i       stage-1 signed carrier sample
//   gain_i          unsigned gain word (RAM read data, valid this cycle)
//   out_sample_o    modulated signed sample
//   out_valid_o     out_sample_o strobe
module dds_am_gain_mult #(
  parameter int DATA_W   = dds_am_pkg::DATA_W,
  parameter int SAMPLE_W = dds_am_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [1:0]          mode_i,
  input  logic [SAMPLE_W-1:0] carrier_i,
  input  logic [DATA_W-1:0]   gain_i,
  output logic [SAMPLE_W-1:0] out_sample_o,
  output logic                out_valid_o
);
  import dds_am_pkg::*;

  localparam int PW = SAMPLE_W + DATA_W + 1;

  logic signed [PW-1:0]  car_ext, gain_ext, prod;
  logic [SAMPLE_W-1:0]   out_d;

  // Gain is zero-extended so it stays non-negative in the signed product.
  assign car_ext  = {{(PW-SAMPLE_W){carrier_i[SAMPLE_W-1]}}, carrier_i};
  assign gain_ext = {{(PW-DATA_W){1'b0}}, gain_i};
  assign prod     = car_ext * gain_ext;

  always_comb begin
    out_d = '0;
    case (mode_i)
      MODE_BYPASS: out_d = carrier_i;
      // |gain| < 2^DATA_W, so the shifted product always fits SAMPLE_W bits.
      MODE_AM:     out_d = SAMPLE_W'(prod >>> DATA_W);
      default:     out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o  <= 1'b0;
      out_sample_o <= '0;
    end else begin
      out_valid_o <= valid_i;
      if (valid_i) out_sample_o <= out_d;
    end
  end

endmodule

// File: rtl/dds_am_table_reader.sv
// dds_am_table_reader
//   Port-2 reader of the DDS1 AM envelope RAM. A phase accumulator walks the
//   table at the programmed modulation rate; each gain word scales the DDS1
//   carrier. Fixed 2-cycle latency from carrier_valid to out_valid.
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   enable, freeze, am_bypass   control levels
//   phase_inc, phase_offset     tuning word, accumulator load value
//   phase_sync                  pulse: reload accumulator (non-IDLE)
//   carrier, carrier_valid      signed carrier sample stream
//   ram_*                       RAM port 2 (address registered in the RAM,
//                               read data returned the following cycle)
//   out_sample, out_valid       modulated sample stream
module dds_am_table_reader #(
  parameter int ADDR_W   = dds_am_pkg::ADDR_W,
  parameter int DATA_W   = dds_am_pkg::DATA_W,
  parameter int PHASE_W  = dds_am_pkg::PHASE_W,
  parameter int SAMPLE_W = dds_am_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                freeze,
  input  logic                am_bypass,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [PHASE_W-1:0]  phase_offset,
  input  logic                phase_sync,
  input  logic [SAMPLE_W-1:0] carrier,
  input  logic                carrier_valid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_clken,
  output logic                ram_write,
  output logic [1:0]          ram_byteenable,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_valid
);
  import dds_am_pkg::*;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  acc_q, acc_d;
  logic [SAMPLE_W-1:0] c1_q;
  logic                v1_q;
  mode_e               m1_q, mode;

  // FSM and accumulator. phase_sync takes precedence over an advance, and
  // enable=0 takes precedence over freeze.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          acc_d   = phase_offset;
        end
      end
      default: begin
        if (phase_sync)                        acc_d = phase_offset;
        else if (state_q == RUN && carrier_valid) acc_d = acc_q + phase_inc;
        if (!enable)                           state_d = IDLE;
        else if (state_q == RUN && freeze)     state_d = HOLD;
        else if (state_q == HOLD && !freeze)   state_d = RUN;
      end
    endcase
  end

  always_comb begin
    if (state_q == IDLE) mode = MODE_ZERO;
    else if (am_bypass)  mode = MODE_BYPASS;
    else                 mode = MODE_AM;
  end

  // Stage 1: the RAM latches the pre-increment address on this same edge,
  // so its read data lines up with c1_q in the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      c1_q    <= '0;
      v1_q    <= 1'b0;
      m1_q    <= MODE_ZERO;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v1_q    <= carrier_valid;
      if (carrier_valid) begin
        c1_q <= carrier;
        m1_q <= mode;
      end
    end
  end

  assign ram_address    = acc_q[PHASE_W-1 -: ADDR_W];
  assign ram_chipselect = (state_q != IDLE);
  assign ram_clken      = 1'b1;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 2'b11;

  dds_am_gain_mult #(
    .DATA_W   (DATA_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_mult (
    .clk          (clk),
    .rst_n        (reset_n),
    .valid_i      (v1_q),
    .mode_i       (m1_q),
    .carrier_i    (c1_q),
    .gain_i       (ram_readdata),
    .out_sample_o (out_sample),
    .out_valid_o  (out_valid)
  );

endmodule

// File: tb/tb_dds_am_table_reader.sv
// tb_dds_am_table_reader
//   Directed bench with a behavioural port-2 RAM, an independent accumulator
//   /FSM model and a timestamped scoreboard of expected output samples.
module tb_dds_am_table_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable, freeze, am_bypass, phase_sync, carrier_valid;
  logic [31:0] phase_inc, phase_offset;
  logic [15:0] carrier;
  logic [9:0]  ram_address;
  logic        ram_chipselect, ram_clken, ram_write;
  logic [1:0]  ram_byteenable;
  logic [15:0] ram_readdata;
  logic [15:0] out_sample;
  logic        out_valid;

  always #5 clk = ~clk;

  dds_am_table_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .freeze         (freeze),
    .am_bypass      (am_bypass),
    .phase_inc      (phase_inc),
    .phase_offset   (phase_offset),
    .phase_sync     (phase_sync),
    .carrier        (carrier),
    .carrier_valid  (carrier_valid),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_clken      (ram_clken),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_readdata   (ram_readdata),
    .out_sample     (out_sample),
    .out_valid      (out_valid)
  );

  // RAM port 2: registered address, unregistered read data.
  logic [15:0] mem [1024];
  logic [9:0]  raddr_q = '0;
  always @(posedge clk)
    if (ram_clken && ram_chipselect && !ram_write) raddr_q <= ram_address;
  assign ram_readdata = mem[raddr_q];

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc_n = 0;
  int          ntests = 0;
  int          nfail = 0;
  bit          mon_en = 1'b0;
  int          st_m = 0;       // 0 IDLE, 1 RUN, 2 HOLD
  logic [31:0] acc_m = '0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every sample must appear exactly two edges after its strobe edge; any
  // other cycle must show out_valid low.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc_n) begin
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_sample", 32'(out_sample), 32'(e.data));
      end else begin
        chk("no_spurious_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  // One clock of stimulus. Entered and left at posedge+1; controls are set
  // by the caller beforehand and sampled at the coming edge.
  task automatic cyc(input logic v, input logic signed [15:0] c);
    logic [15:0] g;
    logic [15:0] e;
    int          p;
    exp_t        x;
    carrier_valid = v;
    carrier       = c;
    chk("ram_address", 32'(ram_address), 32'(acc_m[31:22]));
    chk("ram_chipselect", 32'(ram_chipselect), 32'(st_m != 0));
    if (v) begin
      g = mem[acc_m[31:22]];
      if (st_m == 0)      e = '0;
      else if (am_bypass) e = c;
      else begin
        p = int'(c) * int'({16'b0, g});
        e = 16'(p >>> 16);
      end
      x.data = e;
      x.due  = cyc_n + 2;
      sb.push_back(x);
    end
    case (st_m)
      0: if (enable) begin st_m = 1; acc_m = phase_offset; end
      default: begin
        if (phase_sync)            acc_m = phase_offset;
        else if (st_m == 1 && v)   acc_m = acc_m + phase_inc;
        if (!enable)                    st_m = 0;
        else if (st_m == 1 && freeze)   st_m = 2;
        else if (st_m == 2 && !freeze)  st_m = 1;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 64);
    enable = 0; freeze = 0; am_bypass = 0; phase_sync = 0; carrier_valid = 0;
    phase_inc = '0; phase_offset = '0; carrier = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sample", 32'(out_sample), 32'd0);
    chk("rst_chipselect", 32'(ram_chipselect), 32'd0);
    chk("rst_address", 32'(ram_address), 32'd0);
    chk("ram_clken", 32'(ram_clken), 32'd1);
    chk("ram_write", 32'(ram_write), 32'd0);
    chk("ram_byteenable", 32'(ram_byteenable), 32'd3);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // IDLE: strobes produce zero-valued samples
    cyc(1, 16'sd1234);
    cyc(1, -16'sd77);

    // Stepping through table[i]=i*64 with carrier +16384 -> 16*i
    phase_offset = 32'h0; phase_inc = 32'h0040_0000; enable = 1;
    cyc(0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'sd16384);

    // Freeze: address sits at 5; Nios rewrite is picked up
    freeze = 1;
    cyc(0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'sd16384);
    chk("hold_address", 32'(ram_address), 32'd5);
    cyc(0, 0);
    mem[5] = 16'h0;
    cyc(1, 16'sd16384);
    freeze = 0;
    cyc(0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'sd16384);
    cyc(0, 0);
    mem[5] = 16'(5 * 64);

    // phase_sync coinciding with an advance: load wins
    phase_offset = 32'h0100_0000; phase_sync = 1;
    cyc(1, 16'sd16384);
    phase_sync = 0;
    chk("sync_address", 32'(ram_address), 32'd4);
    cyc(1, 16'sd16384);

    // enable falls mid-stream: in-flight sample keeps AM mode, then zeros
    enable = 0;
    cyc(1, 16'sd16384);
    cyc(1, 16'sd16384);
    cyc(1, 16'sd16384);

    // Accumulator wrap: 1023, 0, 1
    phase_offset = 32'hFFC0_0000; enable = 1;
    cyc(0, 0);
    chk("wrap_start", 32'(ram_address), 32'd1023);
    for (int i = 0; i < 3; i++) cyc(1, 16'sd1000);
    chk("wrap_after", 32'(ram_address), 32'd2);

    // Bypass vs AM at gain 0x8000 with full-scale negative carrier
    enable = 0;
    cyc(0, 0);
    phase_offset = 32'h8000_0000; phase_inc = 32'h0; enable = 1;
    cyc(0, 0);
    am_bypass = 1;
    cyc(1, -16'sd32768);
    am_bypass = 0;
    cyc(1, -16'sd32768);

    // Gain 0xFFFF and gain 0 boundaries
    cyc(0, 0);
    mem[512] = 16'hFFFF;
    cyc(1, 16'sd32767);
    cyc(1, -16'sd32768);
    cyc(0, 0);
    mem[512] = 16'h0;
    cyc(1, -16'sd12345);

    // Asynchronous reset mid-stream
    phase_inc = 32'h0040_0000;
    cyc(1, 16'sd100);
    cyc(1, 16'sd100);
    mon_en = 1'b0;
    carrier_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("amid_out_valid", 32'(out_valid), 32'd0);
    chk("amid_out_sample", 32'(out_sample), 32'd0);
    chk("amid_chipselect", 32'(ram_chipselect), 32'd0);
    chk("amid_address", 32'(ram_address), 32'd0);
    sb.delete();
    st_m = 0; acc_m = '0; enable = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    cyc(1, 16'sd500);
    cyc(1, 16'sd500);
    phase_offset = 32'h0; enable = 1;
    cyc(0, 0);
    cyc(1, 16'sd16384);
    cyc(1, 16'sd16384);

    for (int i = 0; i < 4; i++) cyc(0, 0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dds_am_table_reader.md
Name: dds_am_table_reader

Overview:
- Read-side consumer of the DDS1 amplitude-modulation lookup RAM. The Nios II writes the 1024x16 AM envelope through port 1; this block owns port 2.
- A phase accumulator steps through the table at a programmable modulation rate. Each returned gain word multiplies the DDS1 carrier sample stream.
- The result feeds the DAC path with a fixed 2-cycle latency.

Parameters:
- ADDR_W, 10, table address width (1024 words).
- DATA_W, 16, table word and gain width (unsigned).
- PHASE_W, 32, modulation phase accumulator width.
- SAMPLE_W, 16, signed carrier/output sample width.

Ports:
- clk  in  1  system clock; the RAM port-2 clock is the same clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  AM run enable (level, from control register).
- freeze  in  1  hold accumulator; current gain keeps applying.
- am_bypass  in  1  output = carrier exactly, no table gain.
- phase_inc  in  PHASE_W  modulation tuning word, sampled on each carrier_valid.
- phase_offset  in  PHASE_W  accumulator load value.
- phase_sync  in  1  one-cycle pulse: reload accumulator with phase_offset.
- carrier  in  SAMPLE_W  signed DDS1 carrier sample.
- carrier_valid  in  1  sample strobe.
- ram_address  out  ADDR_W  to RAM address2.
- ram_chipselect  out  1  to chipselect2.
- ram_clken  out  1  to clken2; constant 1.
- ram_write  out  1  to write2; constant 0.
- ram_byteenable  out  2  to byteenable2; constant 2'b11.
- ram_readdata  in  DATA_W  from readdata2.
- out_sample  out  SAMPLE_W  modulated signed sample.
- out_valid  out  1  out_sample strobe.

Behaviour:
- Reset (async, reset_n=0): acc=0, state=IDLE, all pipeline registers 0. out_sample=0, out_valid=0, ram_chipselect=0.
- RAM timing: port 2 registers its address on clk; readdata is unregistered. Data for the address presented in cycle t is valid in cycle t+1.
- ram_address = acc[PHASE_W-1 : PHASE_W-ADDR_W], driven combinationally from the acc register.
- State machine:
  - IDLE -> RUN when enable=1. Entry loads acc=phase_offset.
  - RUN -> HOLD when freeze=1.
  - HOLD -> RUN when freeze=0.
  - RUN or HOLD -> IDLE when enable=0 (takes priority over freeze).
- ram_chipselect=1 in RUN and HOLD, 0 in IDLE.
- Accumulator:
  - Advances acc += phase_inc only in RUN and only on carrier_valid.
  - Wraps modulo 2^PHASE_W with no saturation.
  - phase_sync loads phase_offset in any non-IDLE state. If it coincides with an advance, the load wins.
- Pipeline (the fixed latency is 2 cycles from carrier_valid to out_valid, in every state):
  - Stage 1, at edge t when carrier_valid=1: c1<=carrier, v1<=1, m1<=mode. The RAM latches the pre-increment address.
  - Stage 2, at edge t+1: out_valid<=v1.
    - IDLE mode: out_sample<=0.
    - am_bypass: out_sample<=c1.
    - Otherwise: out_sample<=(c1 * {1'b0,ram_readdata}) >>> 16, with a 33-bit signed product and arithmetic shift (truncation toward -inf).
  - Gain 0 -> 0. Gain 0xFFFF -> carrier*65535/65536.
- HOLD: the address is frozen, so the same gain word is re-read every sample. Table rewrites by the Nios are still picked up.
- Back-to-back carrier_valid every cycle is supported, at full throughput.
- enable falling mid-stream: samples already in stage 1 complete with the mode captured in m1. Subsequent samples output 0.
- No back-pressure: out_valid is a strobe and is not held.

Decomposition:
- Package dds_am_pkg:
  - state enum {IDLE, RUN, HOLD}.
  - Constants ADDR_W, DATA_W, PHASE_W, SAMPLE_W.
  - Mode encoding {MODE_ZERO, MODE_BYPASS, MODE_AM}.
- One sub-module, dds_am_gain_mult: registered signed x unsigned multiply plus shift (stage 2). It is isolated so it can map to a DSP block.
- Accumulator, FSM and stage 1 live in the top.

Test Plan:
- Table filled with table[i]=i*64, phase_offset=0, phase_inc=0x00400000, enable=1, carrier=+16384 every cycle -> ram_address steps 0,1,2,…. out_sample = (16384*i*64)>>16 = 16*i, with the first valid 2 cycles after the first strobe.
- Accumulator near wrap: phase_offset=0xFFC00000, phase_inc=0x00400000 -> addresses 1023, then 0, then 1. No glitch on out_valid.
- freeze=1 after 5 samples -> ram_address stays at 5 and out_sample stays 80. Nios rewrites table[5]=0 -> out_sample becomes 0 on the next strobe. Release freeze -> stepping resumes at 6.
- am_bypass=1 with carrier=-32768 and table gain 0x8000 -> out_sample=-32768 exactly. With bypass=0 -> -16384.
- phase_sync pulse coinciding with carrier_valid in RUN, phase_offset=0x01000000 -> acc=0x01000000 (load wins) and the next address is 4.
- reset_n asserted mid-stream -> out_valid, out_sample, ram_chipselect and acc are all 0 immediately (asynchronously). After release, the block is in IDLE and outputs 0 with valid strobes until enable is reasserted.
